// File: rtl/wave_generator.sv
// -----------------------------------------------------------------------------
// wave_generator
//
// Phase-accumulator waveform source producing square, sawtooth, triangle or
// silent output, scaled by a per-cycle amplitude. Frequency, duty and mode are
// double-buffered: a load strobe captures them into shadow registers, and the
// shadow copy becomes active only at a period boundary (phase wrap), or
// immediately when the generator is idle (enable low or zero increment).
// This keeps waveform periods glitch-free.
//
// Parameters
//   RESOLUTION_BITS (R) : output sample width
//   ACC_WIDTH       (A) : phase accumulator width, must satisfy A >= R+1
//
// Ports
//   clk               in   system clock, rising edge
//   reset             in   asynchronous active-low reset
//   enable            in   run control; when low, phase holds and output is 0
//   load              in   one-cycle strobe capturing frequency/duty/mode
//   frequency_control in   [A-1:0] phase increment per clock
//   duty_control      in   [R-1:0] square-wave high threshold
//   mode              in   [1:0]   00 square, 01 saw, 10 triangle, 11 silence
//   amplitude         in   [R-1:0] output scale, used directly every cycle
//   sync_clear        in   synchronous phase clear
//   wave_out          out  [R-1:0] registered sample
//   period_tick       out  one-cycle pulse after each phase wrap
//   pending           out  shadow settings captured but not yet applied
// -----------------------------------------------------------------------------
module wave_generator #(
    parameter int RESOLUTION_BITS = 8,
    parameter int ACC_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       load,
    input  logic [ACC_WIDTH-1:0]       frequency_control,
    input  logic [RESOLUTION_BITS-1:0] duty_control,
    input  logic [1:0]                 mode,
    input  logic [RESOLUTION_BITS-1:0] amplitude,
    input  logic                       sync_clear,
    output logic [RESOLUTION_BITS-1:0] wave_out,
    output logic                       period_tick,
    output logic                       pending
);

    localparam int R = RESOLUTION_BITS;
    localparam int A = ACC_WIDTH;

    localparam logic [1:0] MODE_SQUARE   = 2'b00;
    localparam logic [1:0] MODE_SAW      = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;

    // Active and shadow settings
    logic [A-1:0] inc_a, inc_s;
    logic [R-1:0] duty_a, duty_s;
    logic [1:0]   mode_a, mode_s;
    logic         pend_q;

    // Phase accumulator and output registers
    logic [A-1:0] phase_p0;
    logic [R-1:0] wave_p1;
    logic         tick_p1;

    // Combinational helpers
    logic [A:0]   sum_p0;
    logic         wrap_p0;
    logic         apply_p0;
    logic [R-1:0] top_p0;
    logic [R-1:0] tri_t_p0;
    logic         half_p0;
    logic [R-1:0] raw_p0;

    // Raw waveform sample from the phase slices. The triangle folds the
    // second half of the period by inverting the rising ramp.
    function automatic logic [R-1:0] raw_sample(
        input logic [R-1:0] top,
        input logic [R-1:0] tri_t,
        input logic         half,
        input logic [1:0]   md,
        input logic [R-1:0] duty
    );
        logic [R-1:0] res;
        res = '0;
        case (md)
            MODE_SQUARE:   res = (top < duty) ? {R{1'b1}} : '0;
            MODE_SAW:      res = top;
            MODE_TRIANGLE: res = half ? ~tri_t : tri_t;
            default:       res = '0;
        endcase
        return res;
    endfunction

    // Scale by (amp+1)/2^R at full 2R+1 width; amp = all-ones is identity.
    function automatic logic [R-1:0] scale_sample(
        input logic [R-1:0] raw,
        input logic [R-1:0] amp
    );
        logic [R:0]   amp_p1;
        logic [2*R:0] prod;
        amp_p1 = {1'b0, amp} + {{R{1'b0}}, 1'b1};
        prod   = {{(R+1){1'b0}}, raw} * {{R{1'b0}}, amp_p1};
        return prod[2*R-1:R];
    endfunction

    // ---- Stage p0: accumulate, detect wrap, derive raw sample -----------------
    always_comb begin
        sum_p0   = {1'b0, phase_p0} + {1'b0, inc_a};
        // sync_clear overrides the add, so its carry must not count as a wrap
        wrap_p0  = enable & ~sync_clear & sum_p0[A];
        // settings may change at a period boundary or whenever the phase is
        // not advancing, since no period is then in progress
        apply_p0 = wrap_p0 | ~enable | (inc_a == '0);
        top_p0   = phase_p0[A-1 -: R];
        tri_t_p0 = phase_p0[A-2 -: R];
        half_p0  = phase_p0[A-1];
        raw_p0   = raw_sample(top_p0, tri_t_p0, half_p0, mode_a, duty_a);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_p0 <= '0;
        end else if (sync_clear) begin
            phase_p0 <= '0;
        end else if (enable) begin
            phase_p0 <= sum_p0[A-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_a  <= '0;
            duty_a <= '0;
            mode_a <= MODE_SQUARE;
            inc_s  <= '0;
            duty_s <= '0;
            mode_s <= MODE_SQUARE;
            pend_q <= 1'b0;
        end else if (apply_p0) begin
            if (load) begin
                // a load on an apply edge bypasses the shadow wait
                inc_a  <= frequency_control;
                duty_a <= duty_control;
                mode_a <= mode;
                inc_s  <= frequency_control;
                duty_s <= duty_control;
                mode_s <= mode;
                pend_q <= 1'b0;
            end else if (pend_q) begin
                inc_a  <= inc_s;
                duty_a <= duty_s;
                mode_a <= mode_s;
                pend_q <= 1'b0;
            end
        end else if (load) begin
            inc_s  <= frequency_control;
            duty_s <= duty_control;
            mode_s <= mode;
            pend_q <= 1'b1;
        end
    end

    // ---- Stage p1: scaled, registered outputs ---------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wave_p1 <= '0;
            tick_p1 <= 1'b0;
        end else begin
            wave_p1 <= enable ? scale_sample(raw_p0, amplitude) : '0;
            tick_p1 <= wrap_p0;
        end
    end

    assign wave_out    = wave_p1;
    assign period_tick = tick_p1;
    assign pending     = pend_q;

endmodule

// File: tb/tb_wave_generator.sv
module tb_wave_generator;

    localparam int R    = 8;
    localparam int A    = 16;
    localparam int FULL = 1 << A;

    logic         clk = 1'b0;
    logic         reset;
    logic         en, ld, sc;
    logic [A-1:0] fc;
    logic [R-1:0] dc, amp;
    logic [1:0]   md;
    logic [R-1:0] wave_out;
    logic         period_tick;
    logic         pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wave_generator #(.RESOLUTION_BITS(R), .ACC_WIDTH(A)) dut (
        .clk(clk),
        .reset(reset),
        .enable(en),
        .load(ld),
        .frequency_control(fc),
        .duty_control(dc),
        .mode(md),
        .amplitude(amp),
        .sync_clear(sc),
        .wave_out(wave_out),
        .period_tick(period_tick),
        .pending(pending)
    );

    // Reference model state, plain integers
    int m_phase, m_inc, m_duty, m_mode;
    int s_inc, s_duty, s_mode;
    int m_pend, m_wave, m_tick;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_inc = 0; m_duty = 0; m_mode = 0;
        s_inc = 0; s_duty = 0; s_mode = 0;
        m_pend = 0; m_wave = 0; m_tick = 0;
    endtask

    function automatic int model_raw();
        int top, t, r;
        top = m_phase / (FULL / (1 << R));
        t   = (m_phase / (FULL / (1 << (R + 1)))) % (1 << R);
        case (m_mode)
            0: r = (top < m_duty) ? (1 << R) - 1 : 0;
            1: r = top;
            2: r = (m_phase >= FULL / 2) ? ((1 << R) - 1 - t) : t;
            default: r = 0;
        endcase
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        int sum, wrap, apply_now, raw;
        sum       = m_phase + m_inc;
        wrap      = (en && !sc && sum >= FULL) ? 1 : 0;
        apply_now = (wrap || !en || m_inc == 0) ? 1 : 0;
        raw       = model_raw();
        m_wave    = en ? (raw * (int'(amp) + 1)) / (1 << R) : 0;
        m_tick    = wrap;
        if (sc)      m_phase = 0;
        else if (en) m_phase = sum % FULL;
        if (apply_now) begin
            if (ld) begin
                m_inc = int'(fc); m_duty = int'(dc); m_mode = int'(md);
                m_pend = 0;
            end else if (m_pend != 0) begin
                m_inc = s_inc; m_duty = s_duty; m_mode = s_mode;
                m_pend = 0;
            end
        end else if (ld) begin
            s_inc = int'(fc); s_duty = int'(dc); s_mode = int'(md);
            m_pend = 1;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_eq("wave", int'(wave_out), m_wave);
        check_eq("tick", int'(period_tick), m_tick);
        check_eq("pending", int'(pending), m_pend);
    endtask

    task automatic drive(input int e, input int l, input int f, input int d,
                         input int m, input int a, input int s);
        en  = (e != 0);
        ld  = (l != 0);
        fc  = A'(f);
        dc  = R'(d);
        md  = 2'(m);
        amp = R'(a);
        sc  = (s != 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, exp;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_eq("rst_wave", int'(wave_out), 0);
        check_eq("rst_tick", int'(period_tick), 0);
        check_eq("rst_pending", int'(pending), 0);
        @(negedge clk);
        reset = 1'b1;

        // Sawtooth, one LSB per cycle, full amplitude
        drive(1, 1, 256, 0, 1, 255, 0);
        step();
        drive(1, 0, 256, 0, 1, 255, 0);
        ticks = 0;
        for (int k = 0; k < 512; k++) begin
            step();
            check_eq("saw_step", int'(wave_out), k % 256);
            if (period_tick) ticks++;
        end
        check_eq("saw_ticks", ticks, 2);
        drive(1, 0, 256, 0, 1, 0, 0);
        for (int k = 0; k < 32; k++) begin
            step();
            check_eq("amp0", int'(wave_out), 0);
        end

        // Square 50% duty, 16-cycle period; applied while idle with phase cleared
        drive(0, 1, 4096, 128, 0, 255, 1);
        step();
        drive(1, 0, 4096, 128, 0, 255, 0);
        for (int k = 0; k < 88; k++) begin
            if (k == 53) drive(1, 1, 8192, 128, 0, 255, 0);
            step();
            if (k == 53) drive(1, 0, 8192, 128, 0, 255, 0);
            if (k < 64) exp = ((k % 16) < 8) ? 255 : 0;
            else        exp = (((k - 64) % 8) < 4) ? 255 : 0;
            check_eq("square", int'(wave_out), exp);
            check_eq("sq_tick", int'(period_tick),
                     (k % 16 == 15 && k < 64) || (k >= 64 && (k - 64) % 8 == 7) ? 1 : 0);
            check_eq("sq_pending", int'(pending), (k >= 53 && k < 63) ? 1 : 0);
        end

        // Triangle, 128-cycle period
        drive(0, 1, 512, 0, 2, 255, 1);
        step();
        drive(1, 0, 512, 0, 2, 255, 0);
        for (int k = 0; k < 256; k++) begin
            step();
            exp = (k % 128 < 64) ? 4 * (k % 128) : 255 - 4 * (k % 128 - 64);
            check_eq("triangle", int'(wave_out), exp);
            check_eq("tri_tick", int'(period_tick), (k % 128 == 127) ? 1 : 0);
        end

        // Enable low mid-run: output 0, no ticks, phase held
        drive(0, 0, 0, 0, 0, 255, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("dis_wave", int'(wave_out), 0);
            check_eq("dis_tick", int'(period_tick), 0);
        end
        drive(1, 0, 0, 0, 0, 255, 0);
        for (int k = 0; k < 127; k++) step();
        // phase now sits one increment before wrap; clear must suppress the tick
        drive(1, 1, 512, 0, 1, 255, 1);
        step();
        check_eq("sc_tick", int'(period_tick), 0);
        drive(1, 0, 512, 0, 1, 255, 0);
        step();
        check_eq("sc_wave", int'(wave_out), 0);
        check_eq("sc_tick2", int'(period_tick), 0);
        for (int k = 0; k < 20; k++) step();

        // Reset mid-period with a pending shadow
        drive(1, 1, 1024, 77, 0, 255, 0);
        step();
        check_eq("pre_rst_pending", int'(pending), 1);
        drive(1, 0, 1024, 77, 0, 255, 0);
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_wave", int'(wave_out), 0);
        check_eq("async_rst_tick", int'(period_tick), 0);
        check_eq("async_rst_pending", int'(pending), 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 1024, 77, 1, 255, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("post_rst_wave", int'(wave_out), 0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            int sel, f;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       f = 0;
                1:       f = int'($urandom_range(1, 16)) * 256;
                2:       f = int'($urandom_range(0, FULL - 1));
                default: f = int'($urandom_range(1, 8)) * 4096;
            endcase
            drive(($urandom_range(0, 9) != 0) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  f,
                  int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 63) == 0) ? 1 : 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_generator.md
WAVE_GENERATOR -- requirements
Module: wave_generator

Interface
REQ-001 SHALL have parameter RESOLUTION_BITS, default 8, output sample width R.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, phase accumulator width A; legal only when A >= R+1.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  run control.
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing frequency_control, duty_control, mode.
REQ-007 SHALL have port frequency_control  input  A  phase increment per clk.
REQ-008 SHALL have port duty_control  input  R  square-wave high threshold.
REQ-009 SHALL have port mode  input  2  00 square, 01 saw, 10 triangle, 11 silence.
REQ-010 SHALL have port amplitude  input  R  output scale, sampled every cycle, no shadowing.
REQ-011 SHALL have port sync_clear  input  1  synchronous phase clear.
REQ-012 SHALL have port wave_out  output  R  registered sample.
REQ-013 SHALL have port period_tick  output  1  registered one-cycle pulse per phase wrap.
REQ-014 SHALL have port pending  output  1  shadow settings captured, not yet applied.

Function
REQ-015 SHALL keep active registers inc_a, duty_a, mode_a and shadow registers inc_s, duty_s, mode_s.
REQ-016 SHALL, when enable=1, update phase <= (phase + inc_a) mod 2^A each cycle; wrap = carry out of that add.
REQ-017 SHALL hold phase when enable=0; wrap forced 0.
REQ-018 SHALL, on load=1, capture inputs into shadow and set pending=1; load while pending overwrites shadow, pending stays 1.
REQ-019 SHALL transfer shadow to active and clear pending at the edge where wrap=1, or at any edge with enable=0 or inc_a=0 (immediate apply).
REQ-020 SHALL, when load=1 coincides with an apply edge, apply that cycle's input values directly; pending stays 0.
REQ-021 SHALL never change active settings at any other edge (glitch-free period boundary).
REQ-022 SHALL, on sync_clear=1, set phase <= 0 at the next edge regardless of enable; no wrap generated; load in same cycle handled normally.
REQ-023 SHALL derive raw sample from the current phase: top = phase[A-1 -: R].
REQ-024 SHALL produce square: raw = (top < duty_a) ? 2^R-1 : 0; duty_a=0 gives constant 0.
REQ-025 SHALL produce saw: raw = top.
REQ-026 SHALL produce triangle: t = phase[A-2 -: R]; raw = phase[A-1] ? ~t : t.
REQ-027 SHALL produce silence: raw = 0, phase keeps running, ticks still produced.
REQ-028 SHALL scale: wave_out <= (raw * (amplitude+1)) >> R, computed at full 2R+1 width, truncated to R; amplitude=2^R-1 is identity.
REQ-029 SHALL register wave_out: value after edge n+1 reflects phase held during cycle n (1-cycle latency).
REQ-030 SHALL force wave_out <= 0 while enable=0.
REQ-031 SHALL assert period_tick for exactly the cycle after each wrap edge.
REQ-032 SHALL hold phase constant when inc_a=0, output following formulas for that phase, no ticks.

Reset
REQ-033 SHALL, on reset=0, immediately clear phase, wave_out, period_tick, pending, all active and shadow registers (mode_a=square, inc_a=0, duty_a=0), independent of clk.
REQ-034 SHALL resume on first rising clk after reset deasserts; reset mid-period discards pending shadow.

Verification
REQ-035 SHALL cover: run saw, assert reset mid-period -> wave_out=0, period_tick=0, pending=0 without clk edge; after release outputs 0 until load.
REQ-036 SHALL cover: load inc=256, mode=01, amplitude=255, enable=1 -> wave_out steps 0,1,2..255 one per cycle, period_tick every 256 cycles; amplitude=0 -> wave_out constant 0.
REQ-037 SHALL cover: load inc=4096, mode=00, duty=128, amplitude=255 -> 8 cycles 255, 8 cycles 0, period_tick every 16 cycles.
REQ-038 SHALL cover: running inc=4096, load inc=8192 at cycle 5 of period -> pending=1 until wrap, old 16-cycle period completes, then 8-cycle periods; pending=0 after wrap edge.
REQ-039 SHALL cover: load inc=512, mode=10, amplitude=255 -> wave_out rises 0,4..252, then 255 falling by 4 to 3, period 128 cycles.
REQ-040 SHALL cover: enable=0 mid-run -> wave_out 0 next edge, phase held, no ticks; sync_clear=1 with enable=1 -> phase 0, next saw sample 0, no spurious tick.
